// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the multi-port hazard unit: forward-select
// codes, default never-forwarded register index and select-width derivation.
package hazard_pkg;

    localparam int PC_REG_DEFAULT = 15;
    localparam int FWD_RF         = 0;

    function automatic int fwd_m(input int p);
        return 2 * p + 1;
    endfunction

    function automatic int fwd_w(input int p);
        return 2 * p + 2;
    endfunction

    // Smallest select width able to encode the register file plus every M/W port.
    function automatic int fsw_min(input int nwp);
        return $clog2(2 * nwp + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_mp_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the datapath, slave the hazard unit.
interface hazard_unit_mp_if
    import hazard_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int NWP   = 2,
    parameter int RW    = 4,
    parameter int CNT_W = 16,
    parameter int FSW   = fsw_min(NWP)
);
    logic [NSRC*RW-1:0]  RA_D;
    logic [NSRC-1:0]     UseD;
    logic [NWP*RW-1:0]   WA_D;
    logic [NWP-1:0]      WE_D;
    logic                McOpD;
    logic [NSRC*RW-1:0]  RA_E;
    logic [NSRC-1:0]     UseE;
    logic [NWP*RW-1:0]   WA_E;
    logic [NWP*RW-1:0]   WA_M;
    logic [NWP*RW-1:0]   WA_W;
    logic [NWP-1:0]      WE_E;
    logic [NWP-1:0]      WE_M;
    logic [NWP-1:0]      WE_W;
    logic                MemToRegE;
    logic                McStartE;
    logic [RW-1:0]       McDestE;
    logic                McDone;
    logic                PCSrcD;
    logic                PCSrcE;
    logic                PCSrcM;
    logic                PCSrcW;
    logic                BranchTakenE;
    logic [NSRC*FSW-1:0] FwdSel;
    logic                EnableF;
    logic                EnableD;
    logic                FlushD;
    logic                FlushE;
    logic                McBusy;
    logic                McErr;
    logic [CNT_W-1:0]    StallCount;

    modport master (
        output RA_D, UseD, WA_D, WE_D, McOpD, RA_E, UseE, WA_E, WA_M, WA_W,
               WE_E, WE_M, WE_W, MemToRegE, McStartE, McDestE, McDone,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  FwdSel, EnableF, EnableD, FlushD, FlushE, McBusy, McErr, StallCount
    );

    modport slave (
        input  RA_D, UseD, WA_D, WE_D, McOpD, RA_E, UseE, WA_E, WA_M, WA_W,
               WE_E, WE_M, WE_W, MemToRegE, McStartE, McDestE, McDone,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output FwdSel, EnableF, EnableD, FlushD, FlushE, McBusy, McErr, StallCount
    );
endinterface

// File: rtl/fwd_pick.sv
// Forward-select for one Execute operand: compares against every M and W write
// port and picks the newest matching producer.
module fwd_pick
    import hazard_pkg::*;
#(
    parameter int NWP    = 2,
    parameter int RW     = 4,
    parameter int FSW    = fsw_min(NWP),
    parameter int PC_REG = PC_REG_DEFAULT
) (
    input  logic [RW-1:0]     ra,
    input  logic              use_src,
    input  logic [NWP*RW-1:0] wa_m,
    input  logic [NWP-1:0]    we_m,
    input  logic [NWP*RW-1:0] wa_w,
    input  logic [NWP-1:0]    we_w,
    output logic [FSW-1:0]    sel
);
    logic [NWP-1:0] hit_m_s;
    logic [NWP-1:0] hit_w_s;
    logic [FSW-1:0] pick_s;
    logic           found_s;

    // Per-port address comparators.
    always_comb begin
        hit_m_s = '0;
        hit_w_s = '0;
        for (int p = 0; p < NWP; p++) begin
            hit_m_s[p] = we_m[p] & (wa_m[p*RW +: RW] == ra);
            hit_w_s[p] = we_w[p] & (wa_w[p*RW +: RW] == ra);
        end
    end

    // Priority encoder: every M port outranks every W port, lower port first.
    always_comb begin
        pick_s  = FSW'(FWD_RF);
        found_s = 1'b0;
        for (int p = 0; p < NWP; p++) begin
            if (!found_s && hit_m_s[p]) begin
                pick_s  = FSW'(fwd_m(p));
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int p = 0; p < NWP; p++) begin
            if (!found_s && hit_w_s[p]) begin
                pick_s  = FSW'(fwd_w(p));
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // The PC register is always read from the register file.
    always_comb begin
        if (!use_src || (ra == RW'(PC_REG))) begin
            sel = FSW'(FWD_RF);
        end else begin
            sel = pick_s;
        end
    end
endmodule

// File: rtl/hazard_unit_mp.sv
// Multi-port pipeline hazard unit: forwarding selects, load/multi-cycle stalls,
// PC-write flushes, one-entry multi-cycle scoreboard and stall-cycle counter.
module hazard_unit_mp
    import hazard_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int NWP    = 2,
    parameter int RW     = 4,
    parameter int PC_REG = PC_REG_DEFAULT,
    parameter int CNT_W  = 16,
    parameter int FSW    = fsw_min(NWP)
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_mp_if.slave  hif
);
    logic [NSRC*FSW-1:0] fwd_s;
    logic                ld_stall_s;
    logic                mc_stall_s;
    logic                pc_pend_s;
    logic                mc_busy_r;
    logic [RW-1:0]       mc_dest_r;
    logic                mc_err_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        fwd_pick #(.NWP(NWP), .RW(RW), .FSW(FSW), .PC_REG(PC_REG)) u_pick (
            .ra      (hif.RA_E[i*RW +: RW]),
            .use_src (hif.UseE[i]),
            .wa_m    (hif.WA_M),
            .we_m    (hif.WE_M),
            .wa_w    (hif.WA_W),
            .we_w    (hif.WE_W),
            .sel     (fwd_s[i*FSW +: FSW])
        );
    end

    // Load-use and multi-cycle (RAW, WAW, structural) stall detection.
    always_comb begin
        ld_stall_s = 1'b0;
        mc_stall_s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (hif.UseD[i] && (hif.RA_D[i*RW +: RW] == hif.WA_E[RW-1:0])) begin
                ld_stall_s = hif.MemToRegE & hif.WE_E[0];
            end else begin
                ld_stall_s = ld_stall_s;
            end
            if (hif.UseD[i] && (hif.RA_D[i*RW +: RW] == mc_dest_r)) begin
                mc_stall_s = mc_busy_r;
            end else begin
                mc_stall_s = mc_stall_s;
            end
        end
        for (int p = 0; p < NWP; p++) begin
            if (hif.WE_D[p] && (hif.WA_D[p*RW +: RW] == mc_dest_r)) begin
                mc_stall_s = mc_busy_r;
            end else begin
                mc_stall_s = mc_stall_s;
            end
        end
        if (hif.McOpD) begin
            mc_stall_s = mc_busy_r;
        end else begin
            mc_stall_s = mc_stall_s;
        end
        pc_pend_s = hif.PCSrcD | hif.PCSrcE | hif.PCSrcM;
    end

    // Pipeline controls, forced quiet while reset is held low.
    always_comb begin
        if (!reset) begin
            hif.FwdSel  = '0;
            hif.EnableF = 1'b0;
            hif.EnableD = 1'b0;
            hif.FlushE  = 1'b0;
            hif.FlushD  = 1'b0;
        end else begin
            hif.FwdSel  = fwd_s;
            hif.EnableF = ~(ld_stall_s | mc_stall_s | pc_pend_s);
            hif.EnableD = ~(ld_stall_s | mc_stall_s);
            hif.FlushE  = ld_stall_s | mc_stall_s | hif.BranchTakenE;
            hif.FlushD  = pc_pend_s | hif.PCSrcW | hif.BranchTakenE;
        end
        hif.McBusy     = mc_busy_r;
        hif.McErr      = mc_err_r;
        hif.StallCount = stall_cnt_r;
    end

    // Scoreboard: a start alongside a done replaces the entry (done is for the old op).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_busy_r <= 1'b0;
            mc_dest_r <= '0;
            mc_err_r  <= 1'b0;
        end else begin
            if (hif.McStartE && (!mc_busy_r || hif.McDone)) begin
                mc_busy_r <= 1'b1;
                mc_dest_r <= hif.McDestE;
            end else if (hif.McDone && !hif.McStartE) begin
                mc_busy_r <= 1'b0;
            end else begin
                mc_busy_r <= mc_busy_r;
            end
            if ((hif.McStartE && mc_busy_r && !hif.McDone) || (hif.McDone && !mc_busy_r)) begin
                mc_err_r <= 1'b1;
            end else begin
                mc_err_r <= mc_err_r;
            end
        end
    end

    // Saturating count of cycles in which decode is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= '0;
        end else if ((ld_stall_s || mc_stall_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mp.sv
// Directed bench for hazard_unit_mp: a rule-level model checked every cycle plus
// hand-computed expectations for forwarding, stalls, scoreboard and reset.
module tb_hazard_unit_mp;
    localparam int NSRC = 4, NWP = 2, RW = 4, PC_REG = 15, CNT_W = 16, FSW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_mp_if #(.NSRC(NSRC), .NWP(NWP), .RW(RW), .CNT_W(CNT_W), .FSW(FSW)) hif();

    hazard_unit_mp #(.NSRC(NSRC), .NWP(NWP), .RW(RW), .PC_REG(PC_REG),
                     .CNT_W(CNT_W), .FSW(FSW)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic             m_busy = 1'b0;
    logic [RW-1:0]    m_dest = '0;
    logic             m_err  = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;

    function automatic int fld(input logic [31:0] v, input int k);
        return int'((v >> (k * RW)) & 32'h0000_000F);
    endfunction

    function automatic int m_fwd(input int i);
        int ra;
        ra = fld(32'(hif.RA_E), i);
        if (!hif.UseE[i] || ra == PC_REG) return 0;
        for (int p = 0; p < NWP; p++)
            if (hif.WE_M[p] && fld(32'(hif.WA_M), p) == ra) return 2 * p + 1;
        for (int p = 0; p < NWP; p++)
            if (hif.WE_W[p] && fld(32'(hif.WA_W), p) == ra) return 2 * p + 2;
        return 0;
    endfunction

    function automatic bit m_ld();
        if (!(hif.MemToRegE && hif.WE_E[0])) return 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (hif.UseD[i] && fld(32'(hif.RA_D), i) == fld(32'(hif.WA_E), 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_mc();
        if (!m_busy) return 1'b0;
        if (hif.McOpD) return 1'b1;
        for (int i = 0; i < NSRC; i++)
            if (hif.UseD[i] && fld(32'(hif.RA_D), i) == int'(m_dest)) return 1'b1;
        for (int p = 0; p < NWP; p++)
            if (hif.WE_D[p] && fld(32'(hif.WA_D), p) == int'(m_dest)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_dest <= '0;
            m_err  <= 1'b0;
            m_cnt  <= '0;
        end else begin
            if (hif.McStartE && (!m_busy || hif.McDone)) begin
                m_busy <= 1'b1;
                m_dest <= hif.McDestE;
            end else if (hif.McDone && !hif.McStartE) begin
                m_busy <= 1'b0;
            end
            if ((hif.McStartE && m_busy && !hif.McDone) || (hif.McDone && !m_busy))
                m_err <= 1'b1;
            if ((m_ld() || m_mc()) && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [NSRC*FSW-1:0] e_fwd;
        bit ld, mc, pcp;
        e_fwd = '0;
        for (int i = 0; i < NSRC; i++)
            e_fwd[i*FSW +: FSW] = reset ? FSW'(m_fwd(i)) : 3'd0;
        ld  = m_ld();
        mc  = m_mc();
        pcp = hif.PCSrcD | hif.PCSrcE | hif.PCSrcM;
        chk("model_FwdSel", 32'(hif.FwdSel), 32'(e_fwd));
        chk("model_EnableF", 32'(hif.EnableF), 32'(reset & !(ld | mc | pcp)));
        chk("model_EnableD", 32'(hif.EnableD), 32'(reset & !(ld | mc)));
        chk("model_FlushE", 32'(hif.FlushE), 32'(reset & (ld | mc | hif.BranchTakenE)));
        chk("model_FlushD", 32'(hif.FlushD), 32'(reset & (pcp | hif.PCSrcW | hif.BranchTakenE)));
        chk("model_McBusy", 32'(hif.McBusy), 32'(m_busy));
        chk("model_McErr", 32'(hif.McErr), 32'(m_err));
        chk("model_StallCount", 32'(hif.StallCount), 32'(m_cnt));
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        hif.RA_D = '0; hif.UseD = '0; hif.WA_D = '0; hif.WE_D = '0; hif.McOpD = 1'b0;
        hif.RA_E = '0; hif.UseE = '0; hif.WA_E = '0; hif.WA_M = '0; hif.WA_W = '0;
        hif.WE_E = '0; hif.WE_M = '0; hif.WE_W = '0; hif.MemToRegE = 1'b0;
        hif.McStartE = 1'b0; hif.McDestE = '0; hif.McDone = 1'b0;
        hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0; hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b0;
        hif.BranchTakenE = 1'b0;
    endtask

    task automatic set_fwd();
        hif.RA_E = 16'h00F3; hif.UseE = 4'b0011;
        hif.WA_M = 8'h30;    hif.WE_M = 2'b10;
        hif.WA_W = 8'h03;    hif.WE_W = 2'b01;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        clr();
        #1 reset = 1'b0;
        set_fwd();
        #1;
        chk("rst_FwdSel", 32'(hif.FwdSel), 32'd0);
        chk("rst_EnableF", 32'(hif.EnableF), 32'd0);
        chk("rst_StallCount", 32'(hif.StallCount), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Forwarding priority
        cyc(); clr(); set_fwd();
        smp();
        chk("fwd_m1_over_w0", 32'(hif.FwdSel[2:0]), 32'd3);
        chk("fwd_pc_reg", 32'(hif.FwdSel[5:3]), 32'd0);
        cyc(); hif.WE_M = 2'b00;
        smp(); chk("fwd_w0", 32'(hif.FwdSel[2:0]), 32'd2);
        cyc(); hif.WA_M = 8'h33; hif.WE_M = 2'b11;
        smp(); chk("fwd_m0", 32'(hif.FwdSel[2:0]), 32'd1);

        // Load-use stall, port 0 only
        cyc(); clr();
        hif.MemToRegE = 1'b1; hif.WA_E = 8'h05; hif.WE_E = 2'b01;
        hif.RA_D = 16'h0500;  hif.UseD = 4'b0100;
        smp();
        chk("ld_EnableF", 32'(hif.EnableF), 32'd0);
        chk("ld_EnableD", 32'(hif.EnableD), 32'd0);
        chk("ld_FlushE", 32'(hif.FlushE), 32'd1);
        cyc(); hif.WA_E = 8'h50; hif.WE_E = 2'b10;
        smp();
        chk("ld_port1_EnableD", 32'(hif.EnableD), 32'd1);
        chk("ld_port1_FlushE", 32'(hif.FlushE), 32'd0);
        chk("ld_StallCount", 32'(hif.StallCount), 32'd1);

        // Multi-cycle RAW: 3 cycles waiting plus the McDone cycle
        cyc(); clr(); hif.McStartE = 1'b1; hif.McDestE = 4'd7;
        cyc(); clr(); hif.RA_D = 16'h0007; hif.UseD = 4'b0001;
        smp();
        chk("mc_busy", 32'(hif.McBusy), 32'd1);
        chk("mc_stall", 32'(hif.EnableD), 32'd0);
        cyc(); cyc();
        cyc(); hif.McDone = 1'b1;
        smp(); chk("mc_done_still_stall", 32'(hif.EnableD), 32'd0);
        cyc(); hif.McDone = 1'b0;
        smp();
        chk("mc_release", 32'(hif.EnableD), 32'd1);
        chk("mc_idle", 32'(hif.McBusy), 32'd0);
        chk("mc_StallCount", 32'(hif.StallCount), 32'd5);

        // Start with done replaces entry, no error
        cyc(); clr(); hif.McStartE = 1'b1; hif.McDestE = 4'd7;
        cyc(); hif.McDone = 1'b1; hif.McDestE = 4'd11;
        cyc(); clr(); hif.RA_D = 16'h000B; hif.UseD = 4'b0001;
        smp();
        chk("swap_busy", 32'(hif.McBusy), 32'd1);
        chk("swap_err", 32'(hif.McErr), 32'd0);
        chk("swap_new_dest", 32'(hif.EnableD), 32'd0);
        cyc(); hif.RA_D = 16'h0007;
        smp(); chk("swap_old_dest", 32'(hif.EnableD), 32'd1);
        // Start while busy: error, entry unchanged
        cyc(); clr(); hif.McStartE = 1'b1; hif.McDestE = 4'd9;
        cyc(); clr(); hif.RA_D = 16'h000B; hif.UseD = 4'b0001;
        smp();
        chk("err_set", 32'(hif.McErr), 32'd1);
        chk("err_dest_kept", 32'(hif.EnableD), 32'd0);
        cyc(); hif.RA_D = 16'h0009;
        smp(); chk("err_not_new", 32'(hif.EnableD), 32'd1);
        cyc(); clr(); hif.McDone = 1'b1;
        // Structural and WAW hazards
        cyc(); clr(); hif.McStartE = 1'b1; hif.McDestE = 4'd2;
        cyc(); clr(); hif.McOpD = 1'b1;
        smp(); chk("mc_structural", 32'(hif.EnableD), 32'd0);
        cyc(); clr(); hif.WA_D = 8'h20; hif.WE_D = 2'b10;
        smp(); chk("mc_waw", 32'(hif.EnableD), 32'd0);
        cyc(); clr(); hif.McDone = 1'b1;

        // PC-write sequence and branch
        cyc(); clr(); hif.PCSrcD = 1'b1;
        smp();
        chk("pcd_EnableF", 32'(hif.EnableF), 32'd0);
        chk("pcd_FlushD", 32'(hif.FlushD), 32'd1);
        chk("pcd_EnableD", 32'(hif.EnableD), 32'd1);
        cyc(); hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b1;
        smp(); chk("pce_EnableF", 32'(hif.EnableF), 32'd0);
        cyc(); hif.PCSrcE = 1'b0; hif.PCSrcM = 1'b1;
        smp(); chk("pcm_EnableF", 32'(hif.EnableF), 32'd0);
        cyc(); hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b1;
        smp();
        chk("pcw_EnableF", 32'(hif.EnableF), 32'd1);
        chk("pcw_FlushD", 32'(hif.FlushD), 32'd1);
        cyc(); clr(); hif.BranchTakenE = 1'b1;
        smp();
        chk("br_FlushD", 32'(hif.FlushD), 32'd1);
        chk("br_FlushE", 32'(hif.FlushE), 32'd1);

        // Reset mid-busy with StallCount=9
        cyc(); clr(); reset = 1'b0;
        cyc(); reset = 1'b1;
        cyc(); hif.McStartE = 1'b1; hif.McDestE = 4'd7;
        cyc(); clr(); hif.RA_D = 16'h0007; hif.UseD = 4'b0001; set_fwd();
        repeat (9) cyc();
        smp();
        chk("pre_rst_count", 32'(hif.StallCount), 32'd9);
        chk("pre_rst_busy", 32'(hif.McBusy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(hif.McBusy), 32'd0);
        chk("async_rst_count", 32'(hif.StallCount), 32'd0);
        chk("async_rst_EnableD", 32'(hif.EnableD), 32'd0);
        chk("async_rst_FlushE", 32'(hif.FlushE), 32'd0);
        chk("async_rst_FwdSel", 32'(hif.FwdSel), 32'd0);
        cyc(); reset = 1'b1;
        smp();
        chk("post_rst_busy", 32'(hif.McBusy), 32'd0);
        chk("post_rst_count", 32'(hif.StallCount), 32'd0);
        chk("post_rst_fwd", 32'(hif.FwdSel[2:0]), 32'd3);
        chk("post_rst_EnableD", 32'(hif.EnableD), 32'd1);

        cyc(); clr();
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
